// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush
// sequencer (slave). Purely level-based: every field is sampled combinationally each cycle.
interface pipe_hazard_ctrl_if;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [1:0]  D_Tuse_rs;
   logic [1:0]  D_Tuse_rt;
   logic [4:0]  E_A3;
   logic [1:0]  E_Tnew;
   logic [4:0]  M_A3;
   logic [1:0]  M_Tnew;
   logic        D_is_md;
   logic        E_md_start;
   logic        E_md_div;
   logic [4:0]  M_ExcCode;
   logic        IntReq;
   logic        stall;
   logic        Req;
   logic        F_PC_Wr;
   logic        D_REG_Wr;
   logic        E_REG_Wr;
   logic        md_busy;
   logic        md_done;
   logic [31:0] stall_cnt;

   modport master (
      output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew,
             D_is_md, E_md_start, E_md_div, M_ExcCode, IntReq,
      input  stall, Req, F_PC_Wr, D_REG_Wr, E_REG_Wr, md_busy, md_done, stall_cnt
   );

   modport slave (
      input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew,
             D_is_md, E_md_start, E_md_div, M_ExcCode, IntReq,
      output stall, Req, F_PC_Wr, D_REG_Wr, E_REG_Wr, md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: register-use hazards, the mult/div
// busy sequencer and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_ctrl_if.slave  hz
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   logic [CNT_W-1:0] md_cnt;
   logic             md_done_q;
   logic [31:0]      stall_cnt_q;
   logic             req;
   logic             rs_hazard;
   logic             rt_hazard;
   logic             md_hazard;
   logic             stall;

   // A hazard exists when a producer's result arrives later than D needs it;
   // E and M are tested independently, and r0 is never a real dependency.
   always_comb begin
      rs_hazard = (hz.D_rs != 5'd0) &&
                  (((hz.E_A3 == hz.D_rs) && (hz.E_Tnew > hz.D_Tuse_rs)) ||
                   ((hz.M_A3 == hz.D_rs) && (hz.M_Tnew > hz.D_Tuse_rs)));
      rt_hazard = (hz.D_rt != 5'd0) &&
                  (((hz.E_A3 == hz.D_rt) && (hz.E_Tnew > hz.D_Tuse_rt)) ||
                   ((hz.M_A3 == hz.D_rt) && (hz.M_Tnew > hz.D_Tuse_rt)));
   end

   assign req       = (hz.M_ExcCode != 5'd0) | hz.IntReq;
   assign md_hazard = hz.D_is_md & ((md_cnt != '0) | hz.E_md_start);
   assign stall     = (rs_hazard | rt_hazard | md_hazard) & ~req;

   // Start is only honoured from idle and never alongside a flush; a flush aborts
   // any running operation without a completion pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt    <= '0;
         md_done_q <= 1'b0;
      end else if (hz.E_md_start && !req && (md_cnt == '0)) begin
         md_cnt    <= hz.E_md_div ? DIV_LD : MULT_LD;
         md_done_q <= 1'b0;
      end else if (req) begin
         md_cnt    <= '0;
         md_done_q <= 1'b0;
      end else if (md_cnt != '0) begin
         md_cnt    <= md_cnt - 1'b1;
         md_done_q <= (md_cnt == CNT_W'(1));
      end else begin
         md_done_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign hz.stall     = stall;
   assign hz.Req       = req;
   assign hz.F_PC_Wr   = ~stall;
   assign hz.D_REG_Wr  = ~stall;
   assign hz.E_REG_Wr  = 1'b1;
   assign hz.md_busy   = (md_cnt != '0);
   assign hz.md_done   = md_done_q;
   assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver queues hand-computed output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz();

   pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   // Vector order: {stall, Req, F_PC_Wr, D_REG_Wr, E_REG_Wr, md_busy, md_done}
   localparam logic [6:0] O_IDLE  = 7'b0011100;
   localparam logic [6:0] O_STALL = 7'b1000100;
   localparam logic [6:0] O_REQ   = 7'b0111100;
   localparam logic [6:0] O_BUSY  = 7'b0000010;
   localparam logic [6:0] O_DONE  = 7'b0000001;

   logic [38:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_sc   = 0;
   logic        cur_stall = 1'b0;

   logic [38:0] mon_e;
   string       mon_nm;
   logic [6:0]  mon_act;

   task automatic drive_idle();
      hz.D_rs = 5'd0;       hz.D_rt = 5'd0;
      hz.D_Tuse_rs = 2'd3;  hz.D_Tuse_rt = 2'd3;
      hz.E_A3 = 5'd0;       hz.E_Tnew = 2'd0;
      hz.M_A3 = 5'd0;       hz.M_Tnew = 2'd0;
      hz.D_is_md = 1'b0;    hz.E_md_start = 1'b0;  hz.E_md_div = 1'b0;
      hz.M_ExcCode = 5'd0;  hz.IntReq = 1'b0;
   endtask

   task automatic expect_o(input string nm, input logic [6:0] e);
      exp_q.push_back({e, 32'(exp_sc)});
      name_q.push_back(nm);
      cur_stall = e[6];
   endtask

   // The counter model advances on every edge at which the expected stall is high.
   task automatic cycle();
      @(posedge clk);
      if (cur_stall && !reset) exp_sc++;
      #1;
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_e  = exp_q.pop_front();
         mon_nm = name_q.pop_front();
         mon_act = {hz.stall, hz.Req, hz.F_PC_Wr, hz.D_REG_Wr, hz.E_REG_Wr,
                    hz.md_busy, hz.md_done};
         n_checks++;
         if (mon_act !== mon_e[38:32]) begin
            n_fail++;
            $display("FAIL %s: outputs got %b want %b", mon_nm, mon_act, mon_e[38:32]);
         end
         n_checks++;
         if (hz.stall_cnt !== mon_e[31:0]) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d want %0d", mon_nm, hz.stall_cnt, mon_e[31:0]);
         end
      end
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      cycle();
      expect_o("reset_state", O_IDLE);
      cycle();
      reset = 1'b0;

      // Load-use through E
      hz.D_rs = 5'd5; hz.D_Tuse_rs = 2'd0; hz.E_A3 = 5'd5; hz.E_Tnew = 2'd1;
      expect_o("load_use", O_STALL);
      cycle();
      hz.E_Tnew = 2'd0;
      expect_o("load_use_clear", O_IDLE);
      cycle();

      // rs hazard through M, then satisfied by a later use
      hz.E_A3 = 5'd0; hz.M_A3 = 5'd5; hz.M_Tnew = 2'd1;
      expect_o("rs_m_hazard", O_STALL);
      cycle();
      hz.D_Tuse_rs = 2'd1;
      expect_o("rs_m_forward", O_IDLE);
      cycle();

      // Zero register and forwardable rt cases
      drive_idle();
      hz.D_rt = 5'd0; hz.D_Tuse_rt = 2'd0; hz.E_A3 = 5'd0; hz.E_Tnew = 2'd2;
      expect_o("rt_zero_reg", O_IDLE);
      cycle();
      drive_idle();
      hz.M_A3 = 5'd7; hz.M_Tnew = 2'd1; hz.D_rt = 5'd7; hz.D_Tuse_rt = 2'd1;
      expect_o("rt_m_forward", O_IDLE);
      cycle();
      hz.D_Tuse_rt = 2'd0;
      expect_o("rt_m_hazard", O_STALL);
      cycle();

      // E not late but M is: independent matches
      drive_idle();
      hz.D_rt = 5'd9; hz.D_Tuse_rt = 2'd1; hz.E_A3 = 5'd9; hz.E_Tnew = 2'd0;
      hz.M_A3 = 5'd9; hz.M_Tnew = 2'd2;
      expect_o("rt_e_ok_m_late", O_STALL);
      cycle();
      hz.E_Tnew = 2'd2; hz.M_Tnew = 2'd0;
      expect_o("rt_e_late_m_ok", O_STALL);
      cycle();

      // Mult: D_is_md stalls in the start cycle and through all busy cycles
      drive_idle();
      hz.D_is_md = 1'b1; hz.E_md_start = 1'b1; hz.E_md_div = 1'b0;
      expect_o("mult_start", O_STALL);
      cycle();
      hz.E_md_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expect_o($sformatf("mult_busy%0d", i + 1), O_STALL | O_BUSY);
         cycle();
      end
      expect_o("mult_done", O_IDLE | O_DONE);
      cycle();
      expect_o("mult_after", O_IDLE);
      cycle();

      // Div aborted by an exception on busy cycle 3
      drive_idle();
      hz.E_md_start = 1'b1; hz.E_md_div = 1'b1;
      expect_o("div_start", O_IDLE);
      cycle();
      hz.E_md_start = 1'b0;
      expect_o("div_busy1", O_IDLE | O_BUSY);
      cycle();
      expect_o("div_busy2", O_IDLE | O_BUSY);
      cycle();
      hz.M_ExcCode = 5'd4; hz.D_is_md = 1'b1;
      expect_o("div_abort_req", O_REQ | O_BUSY);
      cycle();
      drive_idle();
      expect_o("div_aborted", O_IDLE);
      cycle();
      expect_o("div_no_done", O_IDLE);
      cycle();

      // Interrupt beats a register hazard; a start under Req is dropped
      hz.D_rs = 5'd5; hz.D_Tuse_rs = 2'd0; hz.E_A3 = 5'd5; hz.E_Tnew = 2'd1;
      hz.IntReq = 1'b1;
      expect_o("req_over_hazard", O_REQ);
      hz.E_md_start = 1'b1; hz.D_is_md = 1'b1;
      expect_o("req_start_same", O_REQ);
      cycle();
      drive_idle();
      expect_o("req_start_dropped", O_IDLE);
      cycle();

      // Async reset mid-div
      hz.E_md_start = 1'b1; hz.E_md_div = 1'b1;
      expect_o("div2_start", O_IDLE);
      cycle();
      hz.E_md_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_o($sformatf("div2_busy%0d", i + 1), O_IDLE | O_BUSY);
         cycle();
      end
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      exp_sc = 0;
      expect_o("async_reset", O_IDLE);
      cycle();

      // Three stalled cycles after release
      hz.D_rs = 5'd3; hz.D_Tuse_rs = 2'd0; hz.E_A3 = 5'd3; hz.E_Tnew = 2'd2;
      for (int i = 0; i < 3; i++) begin
         expect_o($sformatf("post_reset_stall%0d", i + 1), O_STALL);
         cycle();
      end
      drive_idle();
      expect_o("stall_cnt_three", O_IDLE);
      cycle();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
      end
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
